alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Upstream operand sequencer for the combinational `alu_8bits` core. It collects operand A, operand B and the 2-bit operation select as three consecutive bytes over a single shared 8-bit input bus, then holds them stable on the ALU inputs. It registers the ALU result and offers it downstream on a valid/ready handshake. It sits between the chip-level pin wrapper (`ui_in`/`uio_in`) and `alu_8bits`; the wrapper drives `uo_out` from `res_data`.

## Interface
Parameters:
- DATA_W, 8, operand and result width
- OP_W, 2, operation select width

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- ena  in  1  global enable; 0 freezes all state
- data_in  in  DATA_W  shared byte bus carrying A, then B, then op
- in_valid  in  1  byte on data_in is valid
- in_ready  out  1  loader accepts a byte this cycle
- alu_a  out  DATA_W  operand A to alu_8bits
- alu_b  out  DATA_W  operand B to alu_8bits
- alu_s  out  OP_W  operation select to alu_8bits
- alu_result  in  DATA_W  combinational result from alu_8bits
- res_data  out  DATA_W  registered result
- res_valid  out  1  res_data valid
- res_ready  in  1  downstream consumes the result
- phase  out  2  current load phase, for debug and wrapper status

## Operation
- FSM states: LOAD_A(0), LOAD_B(1), LOAD_OP(2), EXEC(3), HOLD.
- phase equals the state encoding, and reads 3 in both EXEC and HOLD.
- A byte is accepted at an edge where in_valid & in_ready & ena.
- in_ready = ena & (state ∈ {LOAD_A, LOAD_B, LOAD_OP}).
- LOAD_A: accept → a_reg←data_in, go to LOAD_B.
- LOAD_B: accept → b_reg←data_in, go to LOAD_OP.
- LOAD_OP: accept → s_reg←data_in[OP_W-1:0], go to EXEC. data_in[7:2] is ignored.
- EXEC: lasts one cycle. res_data←alu_result, res_valid←1, go to HOLD.
- HOLD: res_valid stays 1 and res_data is stable. When res_ready & ena: res_valid←0, go to LOAD_A.
- alu_a/alu_b/alu_s come straight from a_reg/b_reg/s_reg. They change only on acceptance in their own phase, and keep their last values across transactions.
- No arithmetic is performed here; widths pass through unchanged.
- ena=0: no state, register or output change; in_ready=0; res_valid keeps its value.
- Reset mid-operation: partially loaded bytes are discarded and any pending result is dropped.
- in_valid asserted in EXEC/HOLD is ignored, not queued. res_ready outside HOLD is ignored.
- In HOLD, res_ready and in_valid together: the result is consumed, no byte is taken, and the next byte is accepted one cycle later in LOAD_A.

## Timing
- Reset values: state=LOAD_A; a_reg, b_reg, s_reg, res_data = 0; res_valid=0; in_ready=ena; phase=0.
- One byte per cycle at most; back-to-back acceptance is allowed.
- OP accepted at edge k → EXEC cycle → result registered at edge k+1 → res_valid=1 from edge k+1.
- res_valid falls at the edge where res_ready is sampled high.
- Best-case throughput: one result per 5 cycles (3 load, 1 exec, 1 hold with res_ready=1).
- alu_result is sampled only at the EXEC edge. The combinational path through alu_8bits must close within one clk period.

## Configuration
- Macro ALU_LDR_STROBE_SYNC_EN.
- Defined:
  - in_valid is treated as an asynchronous pin strobe.
  - It passes through a 2-flop synchronizer followed by a rising-edge detector, and the accept condition uses the detected pulse.
  - data_in is sampled at the pulse edge and must be held stable from the strobe rise until at least 3 cycles later.
  - Each strobe loads exactly one byte.
  - Acceptance latency is 2 cycles after the raw rise; strobe edges arriving while in_ready=0 are lost.
- Undefined: in_valid is used directly as a synchronous level-valid with a 0-cycle acceptance path, and no synchronizer flops exist.

## Structure
- Shared package alu_pkg:
  - state enum: LOAD_A, LOAD_B, LOAD_OP, EXEC, HOLD
  - DATA_W/OP_W defaults
  - operation-select constants matching alu_8bits
- Sub-module alu_strb_sync holds the 2-flop synchronizer and edge detector. It is instantiated only under ALU_LDR_STROBE_SYNC_EN.

## Test plan
The bench stubs alu_result = a+b (S=0) and a&b (S=2).
- Reset and basic add: reset, then bytes 0x12, 0x34, 0x00 on consecutive cycles → alu_a=0x12, alu_b=0x34, alu_s=0; res_valid rises 2 edges after the op byte; res_data=0x46.
- Backpressure: hold res_ready=0 for 10 cycles after the result → res_valid stays 1, res_data stays 0x46, in_ready=0; res_ready=1 → back to LOAD_A next cycle.
- Op-byte masking: op byte 0xFE → alu_s=2; with A=0xF0, B=0x3C, res_data=0x30.
- ena gap: drop ena for 4 cycles between the B and OP bytes → no state change, phase stays 2, in_ready=0; the load completes normally afterwards.
- Reset mid-load: rst after the A and B bytes → phase=0, alu_a=alu_b=0, res_valid=0; a fresh 3-byte sequence gives the correct result.
- Strobe mode (macro defined): single-cycle raw strobes 6 cycles apart → one byte loaded per strobe, 2-cycle acceptance delay; a 20-cycle-wide strobe loads only one byte.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and defaults for the alu_8bits operand loader.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Default operand/result width and operation-select width.
    parameter int ALU_DATA_W = 8;
    parameter int ALU_OP_W   = 2;

    // Loader sequencing states. HOLD sits outside the 2-bit phase range and
    // is reported to the outside world with the same phase value as EXEC.
    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        HOLD    = 3'd4
    } ldr_state_e;

    // Operation-select encodings understood by alu_8bits.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } alu_op_e;

    // Map a loader state onto the 2-bit debug/status phase.
    function automatic logic [1:0] state_to_phase(input ldr_state_e s);
        logic [1:0] p;
        if (s == HOLD) begin
            p = 2'd3;
        end else begin
            p = s[1:0];
        end
        return p;
    endfunction

    // True while the loader is collecting bytes.
    function automatic logic is_load_state(input ldr_state_e s);
        return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_OP);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_strb_sync.sv
// -----------------------------------------------------------------------------
// alu_strb_sync
// Two-flop synchronizer plus rising-edge detector for an asynchronous byte
// strobe pin. Only built when ALU_LDR_STROBE_SYNC_EN is defined; without the
// macro this file contributes no hardware.
// -----------------------------------------------------------------------------
`ifdef ALU_LDR_STROBE_SYNC_EN
module alu_strb_sync (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic strobe_raw,
    output logic strobe_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic sync_q3;

    // Synchronize the raw strobe and keep one extra stage for edge detection;
    // the chain freezes with ena like every other flop in the loader.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else if (ena) begin
            // NOTE: non-blocking assignments let each stage see the previous
            // stage's old value, which is what makes this a shift chain.
            sync_q1 <= strobe_raw;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    // One-cycle pulse on the synchronized rising edge of the strobe.
    assign strobe_pulse = sync_q2 & ~sync_q3;

endmodule : alu_strb_sync
`endif

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Collects operand A, operand B and the operation select as three bytes over
// one shared bus, holds them on the alu_8bits inputs, registers the ALU result
// and presents it on a valid/ready handshake.
//
// Build option: ALU_LDR_STROBE_SYNC_EN
//   defined   - in_valid is an asynchronous strobe; it is synchronized and
//               edge-detected, and one byte is loaded per strobe.
//   undefined - in_valid is a synchronous level-valid used directly.
// -----------------------------------------------------------------------------
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_s,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        phase
);

    ldr_state_e        state;
    ldr_state_e        state_nxt;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [OP_W-1:0]   s_reg;
    logic [DATA_W-1:0] res_reg;
    logic              res_vld_reg;

    logic              byte_valid;
    logic              accept;
    logic              load_a;
    logic              load_b;
    logic              load_s;
    logic              capture_res;
    logic              release_res;

    // Upper bits of the op byte carry no meaning and are dropped.
    logic              unused_op_bits;
    assign unused_op_bits = ^data_in[DATA_W-1:OP_W];

`ifdef ALU_LDR_STROBE_SYNC_EN
    alu_strb_sync u_strb_sync (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .strobe_raw   (in_valid),
        .strobe_pulse (byte_valid)
    );
`else
    assign byte_valid = in_valid;
`endif

    assign in_ready = ena & is_load_state(state);
    assign accept   = byte_valid & in_ready;

    // Next state and per-register load strobes.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_s      = 1'b0;
        capture_res = 1'b0;
        release_res = 1'b0;

        unique case (state)
            LOAD_A: begin
                if (accept) begin
                    load_a    = 1'b1;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (accept) begin
                    load_b    = 1'b1;
                    state_nxt = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (accept) begin
                    load_s    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (ena) begin
                    capture_res = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (ena && res_ready) begin
                    release_res = 1'b1;
                    state_nxt   = LOAD_A;
                end
            end
            default: begin
                state_nxt = LOAD_A;
            end
        endcase
    end

    // State register; ena low freezes the sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_A;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Operand registers; each loads only on acceptance in its own phase.
    always_ff @(posedge clk) begin
        // NOTE: these are plain registers, not a memory, so they take a reset
        // value and the ALU inputs are defined straight out of reset.
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
        end else begin
            if (load_a) begin
                a_reg <= data_in;
            end
            if (load_b) begin
                b_reg <= data_in;
            end
            if (load_s) begin
                s_reg <= data_in[OP_W-1:0];
            end
        end
    end

    // Result register and valid flag; valid drops when the result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg     <= '0;
            res_vld_reg <= 1'b0;
        end else if (capture_res) begin
            res_reg     <= alu_result;
            res_vld_reg <= 1'b1;
        end else if (release_res) begin
            res_vld_reg <= 1'b0;
        end
    end

    assign alu_a     = a_reg;
    assign alu_b     = b_reg;
    assign alu_s     = s_reg;
    assign res_data  = res_reg;
    assign res_valid = res_vld_reg;
    assign phase     = state_to_phase(state);

endmodule : alu_operand_loader

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed bench for alu_operand_loader with an alu_8bits stub
// (S=2 -> a&b, otherwise a+b). Strobe-mode sequences are built only when
// ALU_LDR_STROBE_SYNC_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_s;
    logic [7:0] alu_result;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] phase;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_result (alu_result),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .phase      (phase)
    );

    function automatic logic [7:0] alu_stub(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] s);
        return (s == 2'd2) ? (a & b) : 8'(a + b);
    endfunction

    assign alu_result = alu_stub(alu_a, alu_b, alu_s);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // stage: number of bytes collected (0..2), 3 = computing, 4 = result offered
    int         m_stage = 0;
    logic [7:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0] m_s = '0;
    logic       m_valid = 1'b0;
    logic [2:0] m_hist = '0;   // raw in_valid at the last three enabled edges

    always @(posedge clk) begin
        logic take;
        if (rst) begin
            m_stage = 0; m_a = '0; m_b = '0; m_s = '0; m_res = '0; m_valid = 1'b0;
            m_hist  = '0;
        end else if (ena) begin
`ifdef ALU_LDR_STROBE_SYNC_EN
            // raw seen high two edges ago after being low three edges ago
            take   = m_hist[1] & ~m_hist[2];
            m_hist = {m_hist[1:0], in_valid};
`else
            take   = in_valid;
`endif
            if (m_stage < 3) begin
                if (take) begin
                    if (m_stage == 0) m_a = data_in;
                    else if (m_stage == 1) m_b = data_in;
                    else m_s = data_in[1:0];
                    m_stage++;
                end
            end else if (m_stage == 3) begin
                m_res   = alu_stub(m_a, m_b, m_s);
                m_valid = 1'b1;
                m_stage = 4;
            end else if (res_ready) begin
                m_valid = 1'b0;
                m_stage = 0;
            end
        end
    end

    // Compare every cycle, mid-period, once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready",  in_ready,  ena && (m_stage < 3));
            check("cmp_phase",     phase,     (m_stage == 4) ? 3 : m_stage);
            check("cmp_alu_a",     alu_a,     m_a);
            check("cmp_alu_b",     alu_b,     m_b);
            check("cmp_alu_s",     alu_s,     m_s);
            check("cmp_res_valid", res_valid, m_valid);
            check("cmp_res_data",  res_data,  m_res);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1ns after a rising edge and are held across the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        data_in  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef ALU_LDR_STROBE_SYNC_EN
        // hold the byte until the synchronized pulse has taken it
        repeat (5) step();
`endif
    endtask

    task automatic wait_result(input string name);
        int n = 0;
        while (!res_valid && n < 30) begin
            step();
            n++;
        end
        check(name, res_valid, 1'b1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ena = 1'b1; data_in = '0; in_valid = 1'b0; res_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // Reset state
        check("rst_phase",     phase,     2'd0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_alu_a",     alu_a,     8'h00);
        check("rst_res_data",  res_data,  8'h00);

        // Basic add: 0x12 + 0x34
`ifndef ALU_LDR_STROBE_SYNC_EN
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        check("add_exec_phase", phase,     2'd3);
        check("add_exec_valid", res_valid, 1'b0);
        step();
        check("add_valid_edge2", res_valid, 1'b1);
`else
        // Strobe timing: accepted on the second edge after the raw rise
        data_in = 8'h12; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("strb_lat_e0", phase, 2'd0);
        step();
        check("strb_lat_e1", phase, 2'd0);
        step();
        check("strb_lat_e2", phase, 2'd1);
        repeat (3) step();
        send_byte(8'h34);
        send_byte(8'h00);
        wait_result("add_wait");
`endif
        check("add_alu_a", alu_a,    8'h12);
        check("add_alu_b", alu_b,    8'h34);
        check("add_alu_s", alu_s,    2'd0);
        check("add_res",   res_data, 8'h46);

        // Backpressure: result held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            data_in = 8'h99; in_valid = 1'b1;
            step();
            check("bp_valid",    res_valid, 1'b1);
            check("bp_data",     res_data,  8'h46);
            check("bp_in_ready", in_ready,  1'b0);
        end
        in_valid = 1'b0;
        consume();
        check("bp_release_phase", phase,     2'd0);
        check("bp_release_valid", res_valid, 1'b0);
        repeat (6) step();

        // Op-byte masking: 0xFE selects AND
        send_byte(8'hF0);
        send_byte(8'h3C);
        send_byte(8'hFE);
        wait_result("mask_wait");
        check("mask_alu_s", alu_s,    2'd2);
        check("mask_res",   res_data, 8'h30);

`ifndef ALU_LDR_STROBE_SYNC_EN
        // res_ready and in_valid together in HOLD: no byte taken this cycle
        res_ready = 1'b1; in_valid = 1'b1; data_in = 8'hAA;
        step();
        res_ready = 1'b0;
        check("hold_both_phase", phase, 2'd0);
        check("hold_both_alu_a", alu_a, 8'hF0);
        step();
        in_valid = 1'b0;
        check("hold_both_next_a", alu_a, 8'hAA);
        send_byte(8'h10);
        send_byte(8'h00);
        wait_result("hold_both_wait");
        check("hold_both_res", res_data, 8'hBA);
        consume();
`else
        consume();
`endif

        // ena gap between B and OP bytes
        send_byte(8'h0F);
        send_byte(8'h01);
        ena = 1'b0; in_valid = 1'b1; data_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ena_phase",    phase,    2'd2);
            check("ena_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        ena = 1'b1;
        send_byte(8'h00);
        wait_result("ena_wait");
        check("ena_res", res_data, 8'h10);
        consume();
        repeat (4) step();

        // Reset mid-load
        send_byte(8'h77);
        send_byte(8'h88);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_phase", phase,     2'd0);
        check("midrst_alu_a", alu_a,     8'h00);
        check("midrst_alu_b", alu_b,     8'h00);
        check("midrst_valid", res_valid, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        wait_result("midrst_wait");
        check("midrst_res", res_data, 8'h03);

        // Reset with a pending result drops it
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("pend_rst_valid", res_valid, 1'b0);
        check("pend_rst_data",  res_data,  8'h00);

`ifdef ALU_LDR_STROBE_SYNC_EN
        // A 20-cycle-wide strobe loads exactly one byte
        data_in = 8'h21; in_valid = 1'b1;
        repeat (20) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("wide_phase", phase, 2'd1);
        check("wide_alu_a", alu_a, 8'h21);
        send_byte(8'h05);
        send_byte(8'h00);
        wait_result("wide_wait");
        check("wide_res", res_data, 8'h26);
        consume();
`endif

        repeat (3) step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_operand_loader
